vram_pixel_fetch: RTL and testbench

- Scanout stage directly downstream of the 64K x 16 VRAM.
- On each line start it computes the line's word addresses and issues 16-bit reads to the VRAM port.
- Each read word is buffered and unpacked into four 4-bit pixel indices, delivered on a valid/ready stream to the palette/video output stage.
- Reads are throttled so the internal word FIFO never overflows under consumer backpressure.

---
 rtl/vram_pixel_fetch.sv | 138 +++++++++++++
 tb/tb_vram_pixel_fetch.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_pixel_fetch.sv
// vram_pixel_fetch
// Scanout fetch stage that sits directly after the 64K x 16 VRAM. On a
// line_start_i pulse it computes the line's first word address, reads
// WORDS_PER_LINE consecutive words (wrapping silently at 0xFFFF), buffers
// them in a small word FIFO and unpacks each word into four 4-bit palette
// indices, low nibble first.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   line_start_i            1-cycle pulse: start (or restart) a line
//   line_y_i, base_addr_i   line number / frame base, sampled with line_start_i
//   vram_sel_o              VRAM read strobe (this block never writes)
//   vram_address_o          word address, 0 when vram_sel_o=0
//   vram_data_i             read data, valid one cycle after vram_sel_o
//   pixel_valid_o/ready_i   pixel stream handshake
//   pixel_o                 palette index (0 when not valid)
//   busy_o                  line in progress (FETCH or DRAIN)
//   dbg_state               current FSM state, for checkers
//
// Pixel handshake: a transfer happens on a rising clk edge where
// pixel_valid_o and pixel_ready_i are both 1. Once pixel_valid_o is 1 it
// stays 1, and pixel_o stays unchanged, until that transfer happens; only a
// line restart or reset may withdraw it.
module vram_pixel_fetch #(
  parameter int H_RES      = 640,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        line_start_i,
  input  logic [9:0]  line_y_i,
  input  logic [15:0] base_addr_i,
  output logic        vram_sel_o,
  output logic [15:0] vram_address_o,
  input  logic [15:0] vram_data_i,
  output logic        pixel_valid_o,
  input  logic        pixel_ready_i,
  output logic [3:0]  pixel_o,
  output logic        busy_o,
  output logic [1:0]  dbg_state
);

  localparam int WORDS_PER_LINE = H_RES / 4;
  localparam int CW = $clog2(WORDS_PER_LINE + 1);
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state;
  logic [15:0]   line_addr;
  logic [CW-1:0] word_cnt;
  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [NW-1:0] fifo_count;
  logic [NW-1:0] count_nxt;
  logic          inflight;
  logic [1:0]    nib_ptr;

  logic [15:0]   line_addr_calc;
  logic          issue;
  logic          last_issue;
  logic          push;
  logic          xfer;
  logic          pop;
  logic [15:0]   head_word;

  // Row offset truncated to 16 bits; the whole address space wraps.
  assign line_addr_calc = base_addr_i + 16'(32'(line_y_i) * 32'(WORDS_PER_LINE));

  // A slot is reserved for every read in flight, so a returning word always
  // has room even if the consumer stalls. No read is issued in a restart
  // cycle: its return would belong to the line being abandoned.
  assign issue = (state == S_FETCH) && !line_start_i &&
                 ((32'(fifo_count) + 32'(inflight)) < 32'(FIFO_DEPTH));
  assign last_issue = issue && (word_cnt == CW'(WORDS_PER_LINE - 1));

  // The in-flight flag is cleared by restart and reset, which is what
  // discards a stale return.
  assign push = inflight && !line_start_i;
  assign xfer = pixel_valid_o && pixel_ready_i;
  assign pop  = xfer && (nib_ptr == 2'd3);
  assign count_nxt = fifo_count + NW'(push) - NW'(pop);

  assign head_word      = fifo_mem[rd_ptr];
  assign vram_sel_o     = issue;
  assign vram_address_o = issue ? (line_addr + 16'(word_cnt)) : 16'd0;
  assign pixel_valid_o  = (fifo_count != '0);
  assign pixel_o        = pixel_valid_o ? head_word[{nib_ptr, 2'b00} +: 4] : 4'd0;
  assign busy_o         = (state != S_IDLE);
  assign dbg_state      = state;

  // Storage is not reset; nothing reads an entry before it is written.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= vram_data_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      line_addr  <= 16'd0;
      word_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      inflight   <= 1'b0;
      nib_ptr    <= 2'd0;
    end else if (line_start_i) begin
      // Start or abort-and-restart: takes precedence over any pop this cycle.
      state      <= S_FETCH;
      line_addr  <= line_addr_calc;
      word_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      inflight   <= 1'b0;
      nib_ptr    <= 2'd0;
    end else begin
      inflight   <= issue;
      fifo_count <= count_nxt;
      if (issue) word_cnt <= word_cnt + CW'(1);
      if (push)  wr_ptr   <= wr_ptr + PW'(1);
      if (xfer)  nib_ptr  <= nib_ptr + 2'd1;
      if (pop)   rd_ptr   <= rd_ptr + PW'(1);
      case (state)
        S_FETCH: if (last_issue) state <= S_DRAIN;
        // No reads are issued in DRAIN, so an empty FIFO after this cycle
        // means the last nibble has gone and nothing is in flight.
        S_DRAIN: if (count_nxt == '0) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_pixel_fetch.sv
// Self-checking bench for vram_pixel_fetch (default parameters). Expected
// pixels and addresses come from a line-level model: word k of a line is
// read from (base + y*WORDS_PER_LINE + k) mod 65536, and pixel n is nibble
// (n mod 4) of word n/4.
module tb_vram_pixel_fetch;

  localparam int H_RES      = 640;
  localparam int WPL        = H_RES / 4;
  localparam int FIFO_DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        line_start_i = 1'b0;
  logic [9:0]  line_y_i = '0;
  logic [15:0] base_addr_i = '0;
  logic        vram_sel_o;
  logic [15:0] vram_address_o;
  logic [15:0] vram_data_i = '0;
  logic        pixel_valid_o;
  logic        pixel_ready_i = 1'b0;
  logic [3:0]  pixel_o;
  logic        busy_o;
  logic [1:0]  dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  vram_pixel_fetch #(.H_RES(H_RES), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .line_start_i   (line_start_i),
    .line_y_i       (line_y_i),
    .base_addr_i    (base_addr_i),
    .vram_sel_o     (vram_sel_o),
    .vram_address_o (vram_address_o),
    .vram_data_i    (vram_data_i),
    .pixel_valid_o  (pixel_valid_o),
    .pixel_ready_i  (pixel_ready_i),
    .pixel_o        (pixel_o),
    .busy_o         (busy_o),
    .dbg_state      (dbg_state)
  );

  // ---------------- VRAM model: data one cycle after the strobe ----------------
  logic [15:0] vmem [0:65535];
  always @(posedge clk) vram_data_i <= vram_sel_o ? vmem[vram_address_o] : 16'hDEAD;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [3:0]  exp_q[$];
  logic [15:0] addr_q[$];
  int          strobe_cnt = 0;
  bit          hold_ok = 1'b0;
  logic [3:0]  hold_pix = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (vram_sel_o) begin
        strobe_cnt++;
        if (addr_q.size() == 0) check("extra_strobe", 1, 0);
        else check("vram_addr", vram_address_o, addr_q.pop_front());
      end
      if (hold_ok) begin
        check("hold_valid", pixel_valid_o, 1);
        check("hold_pixel", pixel_o, hold_pix);
      end
      if (pixel_valid_o && pixel_ready_i) begin
        if (exp_q.size() == 0) check("extra_pixel", 1, 0);
        else check("pixel", pixel_o, exp_q.pop_front());
      end
      hold_ok  = pixel_valid_o && !pixel_ready_i;
      hold_pix = pixel_o;
    end else begin
      hold_ok = 1'b0;
    end
  end

  // ---------------- model / drivers ----------------
  function automatic logic [15:0] line_addr(input logic [15:0] base, input logic [9:0] y);
    return base + 16'(int'(y) * WPL);
  endfunction

  task automatic build_line(input logic [15:0] base, input logic [9:0] y);
    logic [15:0] la;
    la = line_addr(base, y);
    exp_q.delete();
    addr_q.delete();
    for (int k = 0; k < WPL; k++) addr_q.push_back(la + 16'(k));
    for (int n = 0; n < H_RES; n++) begin
      logic [15:0] w;
      w = vmem[la + 16'(n / 4)];
      exp_q.push_back(4'(w >> (4 * (n % 4))));
    end
  endtask

  task automatic start_line(input logic [15:0] base, input logic [9:0] y);
    @(posedge clk); #1;
    line_start_i = 1'b1;
    line_y_i     = y;
    base_addr_i  = base;
    @(posedge clk); #1;
    line_start_i = 1'b0;
    line_y_i     = 10'($urandom);
    base_addr_i  = 16'($urandom);
    hold_ok      = 1'b0;
    build_line(base, y);
    strobe_cnt   = 0;
  endtask

  // mode 0: ready held high; mode 1: ready random each cycle
  task automatic run_until_done(input int mode, input int budget);
    bit done;
    done = 1'b0;
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      @(posedge clk); #1;
      pixel_ready_i = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !busy_o) done = 1'b1;
    end
    check("line_done_in_budget", done, 1);
    check("pixels_left", exp_q.size(), 0);
    check("addrs_left", addr_q.size(), 0);
    check("strobe_total", strobe_cnt, WPL);
    check("busy_end", busy_o, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_sel"},   vram_sel_o, 0);
    check({tag, "_addr"},  vram_address_o, 0);
    check({tag, "_valid"}, pixel_valid_o, 0);
    check({tag, "_pixel"}, pixel_o, 0);
    check({tag, "_busy"},  busy_o, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] base;
    logic [9:0]  y;
    logic [15:0] la;
    int          guard;

    for (int a = 0; a < 65536; a++) vmem[a] = 16'($urandom);

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Known words: pixel sequence 0..7 at line start, ready held high.
    vmem[16'h0240] = 16'h3210;
    vmem[16'h0241] = 16'h7654;
    start_line(16'h0100, 10'd2);
    @(negedge clk);
    check("first_strobe", vram_sel_o, 1);
    check("first_addr", vram_address_o, 16'h0240);
    run_until_done(0, 2000);

    // Backpressure: only FIFO_DEPTH reads may be issued while ready is low.
    pixel_ready_i = 1'b0;
    start_line(16'($urandom), 10'($urandom_range(0, 479)));
    repeat (50) @(negedge clk);
    #1;
    check("throttle_strobes", strobe_cnt, FIFO_DEPTH);
    check("throttle_valid", pixel_valid_o, 1);
    check("throttle_sel_off", vram_sel_o, 0);
    run_until_done(0, 3000);

    // Address wrap past 0xFFFF.
    start_line(16'hFFFE, 10'd0);
    run_until_done(1, 4000);

    // Word k of the line holds k; random ready.
    base = 16'($urandom);
    y    = 10'($urandom_range(0, 479));
    la   = line_addr(base, y);
    for (int k = 0; k < WPL; k++) vmem[la + 16'(k)] = 16'(k);
    start_line(base, y);
    run_until_done(1, 4000);

    // Abort at pixel 37 of line 5, restart on line 6.
    base = 16'($urandom);
    start_line(base, 10'd5);
    guard = 0;
    while ((H_RES - exp_q.size()) < 37 && guard < 3000) begin
      @(posedge clk); #1;
      pixel_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk); #1;
      guard++;
    end
    check("abort_point", H_RES - exp_q.size(), 37);
    start_line(base, 10'd6);
    check("abort_valid_drop", pixel_valid_o, 0);
    check("abort_busy", busy_o, 1);
    run_until_done(1, 4000);

    // Restart in the same cycle as the final pop.
    start_line(16'($urandom), 10'($urandom_range(0, 479)));
    guard = 0;
    while (exp_q.size() > 1 && guard < 3000) begin
      @(posedge clk); #1;
      pixel_ready_i = 1'b1;
      @(negedge clk); #1;
      guard++;
    end
    check("near_end", exp_q.size(), 1);
    start_line(16'($urandom), 10'($urandom_range(0, 479)));
    check("restart_busy", busy_o, 1);
    run_until_done(0, 3000);

    // Reset mid-FETCH with a read in flight.
    pixel_ready_i = 1'b0;
    start_line(16'($urandom), 10'($urandom_range(0, 479)));
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    exp_q.delete();
    addr_q.delete();
    @(posedge clk);
    @(negedge clk);
    reset_n       = 1'b1;
    strobe_cnt    = 0;
    pixel_ready_i = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check("post_reset_strobes", strobe_cnt, 0);
    check("post_reset_busy", busy_o, 0);
    check("post_reset_valid", pixel_valid_o, 0);
    start_line(16'($urandom), 10'($urandom_range(0, 479)));
    run_until_done(1, 4000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
